// File: rtl/alu_result_stage.sv
// ALU result stage: selects one operation result, derives NZCV flags,
// and buffers entries in a small valid/ready FIFO toward writeback.
module alu_result_stage #(
   parameter int N       = 4,
   parameter int NUM_OPS = 10,
   parameter int SEL_W   = 4,
   parameter int DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*(N+1)-1:0] results,
   input  logic [NUM_OPS-1:0]       carry_vec,
   input  logic [NUM_OPS-1:0]       ovf_vec,
   input  logic [SEL_W-1:0]         ALUControl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N:0]               Q,
   output logic [3:0]               flags,
   output logic                     illegal,
   output logic [7:0]               err_count
);

   localparam int W     = N + 1;
   localparam int E     = W + 5;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [E-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       err_q, err_d;

   logic             legal;
   logic [W-1:0]     sel_res;
   logic             sel_c;
   logic             sel_v;
   logic [E-1:0]     entry_d;
   logic [E-1:0]     head;
   logic             push;
   logic             pop;

   assign in_ready  = !rst && (cnt_q < CNT_W'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Illegal opcodes fall back to slot 0 with carry/overflow forced low.
   always_comb begin
      legal   = ({1'b0, ALUControl} < (SEL_W+1)'(NUM_OPS));
      sel_res = '0;
      sel_c   = 1'b0;
      sel_v   = 1'b0;
      for (int k = 0; k < NUM_OPS; k++) begin
         if (legal ? (ALUControl == SEL_W'(k)) : (k == 0)) begin
            sel_res = results[k*W +: W];
            sel_c   = carry_vec[k];
            sel_v   = ovf_vec[k];
         end
      end
      entry_d = {~legal, sel_res[N], ~|sel_res,
                 sel_c & legal, sel_v & legal, sel_res};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
         if (!legal && err_q != 8'hFF)
            err_d = err_q + 8'd1;
      end
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         if (push)
            mem_q[wr_ptr_q] <= entry_d;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign Q         = out_valid ? head[W-1:0] : '0;
   assign flags     = out_valid ? head[W+3:W] : 4'b0000;
   assign illegal   = out_valid & head[E-1];
   assign err_count = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: selection, flags, FIFO flow
// control, illegal-opcode counting and asynchronous reset.
module tb_alu_result_stage;

   localparam int N       = 4;
   localparam int NUM_OPS = 10;
   localparam int SEL_W   = 4;
   localparam int DEPTH   = 2;
   localparam int W       = N + 1;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [NUM_OPS*W-1:0]   results;
   logic [NUM_OPS-1:0]     carry_vec;
   logic [NUM_OPS-1:0]     ovf_vec;
   logic [SEL_W-1:0]       ALUControl;
   logic                   out_valid;
   logic                   out_ready;
   logic [N:0]             Q;
   logic [3:0]             flags;
   logic                   illegal;
   logic [7:0]             err_count;

   int checks = 0;
   int errors = 0;

   alu_result_stage #(
      .N(N), .NUM_OPS(NUM_OPS), .SEL_W(SEL_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .results(results), .carry_vec(carry_vec), .ovf_vec(ovf_vec),
      .ALUControl(ALUControl),
      .out_valid(out_valid), .out_ready(out_ready),
      .Q(Q), .flags(flags), .illegal(illegal),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Target slot gets val; other slots and carry/ovf bits get decoys.
   task automatic drive(input int ctl, input logic [4:0] val,
                        input logic c, input logic v);
      for (int k = 0; k < NUM_OPS; k++)
         results[k*W +: W] = 5'h15 ^ 5'(k);
      ALUControl = SEL_W'(ctl);
      if (ctl < NUM_OPS) begin
         results[ctl*W +: W] = val;
         carry_vec = {NUM_OPS{~c}};
         ovf_vec   = {NUM_OPS{~v}};
         carry_vec[ctl] = c;
         ovf_vec[ctl]   = v;
      end else begin
         results[0 +: W] = val;
         carry_vec = '1;
         ovf_vec   = '1;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   logic [4:0] vals [11];

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      results = '0;
      carry_vec = '0;
      ovf_vec = '0;
      ALUControl = '0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_err", 32'(err_count), 0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      cyc();

      // Legal opcode 3: 10000, carry -> NZCV = 1010
      drive(3, 5'h10, 1'b1, 1'b0);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_q", 32'(Q), 32'h10);
      chk("t1_flags", 32'(flags), 32'b1010);
      chk("t1_illegal", 32'(illegal), 0);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("t1_drain", 32'(out_valid), 0);
      chk("t1_q_zero", 32'(Q), 0);
      chk("t1_flags_zero", 32'(flags), 0);

      // Zero result with overflow -> NZCV = 0101
      drive(2, 5'h00, 1'b0, 1'b1);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("t2_q", 32'(Q), 0);
      chk("t2_flags", 32'(flags), 32'b0101);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // Illegal opcode uses slot 0, forces C=V=0
      drive(12, 5'h07, 1'b1, 1'b1);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("t3_q", 32'(Q), 32'h07);
      chk("t3_flags", 32'(flags), 0);
      chk("t3_illegal", 32'(illegal), 1);
      chk("t3_err", 32'(err_count), 1);
      out_ready = 1'b1;
      cyc();

      drive(15, 5'h01, 1'b1, 1'b1);
      in_valid = 1'b1;
      for (int i = 0; i < 253; i++)
         cyc();
      chk("t3_err_254", 32'(err_count), 254);
      for (int i = 0; i < 47; i++)
         cyc();
      chk("t3_err_sat", 32'(err_count), 255);
      in_valid = 1'b0;
      cyc();
      chk("t3_empty", 32'(out_valid), 0);
      chk("t3_err_hold", 32'(err_count), 255);
      out_ready = 1'b0;

      // Back-pressure: A then B fill the FIFO
      drive(1, 5'h0A, 1'b0, 1'b0);
      in_valid = 1'b1;
      cyc();
      chk("t4_ready_1", 32'(in_ready), 1);
      chk("t4_qa", 32'(Q), 32'h0A);
      drive(5, 5'h1B, 1'b1, 1'b1);
      cyc();
      chk("t4_full", 32'(in_ready), 0);
      chk("t4_hold_a", 32'(Q), 32'h0A);
      chk("t4_hold_fa", 32'(flags), 32'b0000);
      drive(7, 5'h11, 1'b0, 1'b0);
      cyc();
      chk("t4_still_full", 32'(in_ready), 0);
      chk("t4_still_a", 32'(Q), 32'h0A);
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("t4_qb", 32'(Q), 32'h1B);
      chk("t4_fb", 32'(flags), 32'b1011);
      chk("t4_ready_back", 32'(in_ready), 1);
      cyc();
      chk("t4_no_junk", 32'(out_valid), 0);
      out_ready = 1'b0;

      // One entry held; push and pop together for 10 cycles
      for (int i = 0; i < 11; i++)
         vals[i] = 5'(i * 3 + 1);
      drive(0, vals[0], 1'b0, 1'b0);
      in_valid = 1'b1;
      cyc();
      chk("t5_head0", 32'(Q), 32'(vals[0]));
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         drive(i % NUM_OPS, vals[i], 1'b0, 1'b0);
         cyc();
         chk("t5_q", 32'(Q), 32'(vals[i]));
         chk("t5_flags", 32'(flags), 32'({vals[i][4], 3'b000}));
         chk("t5_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b0;
      cyc();
      chk("t5_drained", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Asynchronous reset with two entries buffered
      drive(4, 5'h1C, 1'b1, 1'b0);
      in_valid = 1'b1;
      cyc();
      drive(6, 5'h13, 1'b0, 1'b1);
      cyc();
      in_valid = 1'b0;
      chk("t6_full", 32'(in_ready), 0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_q", 32'(Q), 0);
      chk("t6_flags", 32'(flags), 0);
      chk("t6_err", 32'(err_count), 0);
      chk("t6_ready", 32'(in_ready), 0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_ready_rel", 32'(in_ready), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t6_no_old", 32'(out_valid), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered, flow-controlled successor to the ALU result multiplexer.
- Selects one of NUM_OPS operation results by ALUControl and derives NZCV flags from the selected operation.
- Buffers result and flags in a DEPTH-entry FIFO with valid/ready handshakes on both sides; counts illegal opcodes.
- Sits between the parallel ALU operation units and the register-file/flag writeback.

Parameters:
- N, 4: MSB index of a result; every result and Q is N+1 bits wide.
- NUM_OPS, 10: number of operation result slots, 1..2**SEL_W.
- SEL_W, 4: width of ALUControl.
- DEPTH, 2: output FIFO entries, >=1; pointers wrap modulo DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a result set and opcode.
- in_ready  out  1  stage can accept; asserted exactly when FIFO not full and rst low.
- results  in  NUM_OPS*(N+1)  packed results; slot k at bits [k*(N+1)+N : k*(N+1)].
- carry_vec  in  NUM_OPS  carry-out of each operation.
- ovf_vec  in  NUM_OPS  signed overflow of each operation.
- ALUControl  in  SEL_W  operation select.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- Q  out  N+1  head result.
- flags  out  4  head flags {N,Z,C,V}.
- illegal  out  1  head entry came from an out-of-range opcode.
- err_count  out  8  saturating count of accepted illegal opcodes.

Behaviour:
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Selection at push: sel = ALUControl if ALUControl < NUM_OPS.
  - Otherwise sel = 0, the entry's illegal bit = 1, and C = V = 0 for that entry.
- Flags at push:
  - N = selected result bit N.
  - Z = (selected result == 0).
  - C = carry_vec[sel]; V = ovf_vec[sel] (legal opcodes only).
- Latency: an entry pushed at edge k is visible on Q/flags/illegal with out_valid=1 after edge k when the FIFO was empty. No combinational path from inputs to outputs.
- Q, flags and illegal show the FIFO head and are held stable while out_valid && !out_ready.
- When out_valid=0, Q, flags and illegal read 0.
- FIFO occupancy:
  - in_ready = (count < DEPTH).
  - Full: in_ready=0. A pop frees a slot, but in_ready rises only on the next cycle; there is no same-cycle pass-through when full.
  - Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, order preserved.
  - Empty: out_valid=0; a pop request is ignored.
- err_count increments by 1 on each push with an illegal opcode and saturates at 255. It is never cleared except by reset.
- Inputs are ignored when no push occurs; upstream may change them freely then.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO flushed; count = 0; pointers = 0.
  - out_valid = 0, Q = 0, flags = 0, illegal = 0, err_count = 0, in_ready = 0 while rst is high.
  - in_ready = 1 on the first cycle after rst deasserts.
  - Buffered entries are discarded.
- State: read/write pointers (clog2(DEPTH) bits, minimum 1), count (0..DEPTH), entry storage of N+1+4+1 bits per entry, and err_count.

Test Plan:
- Reset then single push of ALUControl=3 with slot3=5'h10, carry_vec[3]=1, ovf_vec[3]=0 -> next cycle out_valid=1, Q=5'h10, flags=4'b1010, illegal=0.
- Push ALUControl=2 with slot2=0 and ovf_vec[2]=1 -> Q=0, flags=4'b0101.
- Push ALUControl=4'hC (>= NUM_OPS) with slot0=5'h07 -> Q=5'h07, flags=4'b0000, illegal=1, err_count=1. Then 300 illegal pushes -> err_count=255.
- out_ready=0 with back-to-back pushes of A then B (DEPTH=2):
  - in_ready drops after the second push and Q holds A.
  - Raise out_ready -> A then B emitted in order; in_ready returns the cycle after the first pop.
- With one entry held, simultaneous push and pop for 10 cycles -> count stays 1, in_ready stays 1, outputs in push order with no loss or duplication.
- Assert rst asynchronously with 2 entries buffered mid-cycle -> out_valid, Q, flags and err_count go to 0 immediately. After release, in_ready=1 and the old entries never appear.
